// File: rtl/bridge_pkg.sv
// bridge_pkg: shared definitions for the far-side UART bus bridge.
//   - default data/address widths
//   - frame layout helpers: {mode, wdata, addr} with addr in the LSBs
//   - request sequencer FSM state encoding
package bridge_pkg;

    localparam int DFLT_DATA_WIDTH = 8;
    localparam int DFLT_ADDR_WIDTH = 12;

    // Address always sits at the bottom of the frame.
    localparam int ADDR_LSB = 0;

    function automatic int frame_w(input int data_w, input int addr_w);
        return data_w + addr_w + 1;
    endfunction

    function automatic int wdata_lsb(input int addr_w);
        return ADDR_LSB + addr_w;
    endfunction

    function automatic int mode_bit(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_SEND     = 2'd3
    } state_t;

endpackage

// File: rtl/bridge_frame_fifo.sv
// bridge_frame_fifo: synchronous frame buffer, WIDTH x DEPTH.
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   push, push_data     write one entry (caller guarantees space or a same-cycle pop)
//   pop, pop_data       pop_data shows the head; pop advances it (caller guarantees not empty)
//   full, empty, count  occupancy; count is one bit wider than the pointers
module bridge_frame_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/bus_bridge_req_sequencer.sv
// bus_bridge_req_sequencer: far-side stage of the UART bus bridge.
// Buffers {mode, wdata, addr} frames from the UART receiver, replays each as one
// request on the master-port interface, and returns read data via the UART TX.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   u_rx_ready, u_rx_data        incoming frame strobe and frame
//   u_tx_busy, u_tx_en, u_tx_data  UART TX handshake and read byte
//   req_valid/ready/mode/addr/wdata  master-port request
//   rsp_valid, rsp_rdata         master-port response (1-cycle pulse)
//   ovf_err                      sticky: frame dropped because the buffer was full
//   tmo_err                      sticky: response timeout
// Build option: define BRIDGE_RSP_TIMEOUT_EN to bound the response wait to
// TIMEOUT_CYCLES; otherwise WAIT_RSP waits forever and tmo_err is tied 0.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for a buffered frame; pops it into the holding regs
// ST_ISSUE    | req_valid high, waiting for req_ready
// ST_WAIT_RSP | request accepted, waiting for rsp_valid (or timeout)
// ST_SEND     | read byte captured, waiting for the UART TX to go idle
module bus_bridge_req_sequencer
    import bridge_pkg::*;
#(
    parameter int DATA_WIDTH     = DFLT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DFLT_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             u_rx_ready,
    input  logic [DATA_WIDTH+ADDR_WIDTH:0]   u_rx_data,
    input  logic                             u_tx_busy,
    output logic                             u_tx_en,
    output logic [DATA_WIDTH-1:0]            u_tx_data,
    output logic                             req_valid,
    input  logic                             req_ready,
    output logic                             req_mode,
    output logic [ADDR_WIDTH-1:0]            req_addr,
    output logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic                             rsp_valid,
    input  logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             ovf_err,
    output logic                             tmo_err
);
    localparam int FRAME_W   = frame_w(DATA_WIDTH, ADDR_WIDTH);
    localparam int WDATA_LSB = wdata_lsb(ADDR_WIDTH);
    localparam int MODE_BIT  = mode_bit(DATA_WIDTH, ADDR_WIDTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("bus_bridge_req_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
    end

    state_t state, state_nxt;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FRAME_W-1:0] fifo_rd_data;
    logic [CNT_W-1:0]   fifo_count;
    logic               frame_drop;

    logic               capture, tx_fire, tmo_hit;

    logic               hold_mode;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_wdata;

    // A frame arriving while full is still accepted when the head leaves this cycle.
    assign fifo_push  = u_rx_ready && ((fifo_count < CNT_W'(FIFO_DEPTH)) || fifo_pop);
    assign frame_drop = u_rx_ready && fifo_full && !fifo_pop;

    bridge_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data (u_rx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef BRIDGE_RSP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_cnt;

    // Down-counter reloaded whenever we are outside WAIT_RSP, so it starts full on entry;
    // terminal count is reached on the TIMEOUT_CYCLES-th cycle spent waiting.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            if (state != ST_WAIT_RSP) begin
                tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
            if (tmo_hit) begin
                tmo_err <= 1'b1;
            end
        end
    end
`else
    assign tmo_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        capture   = 1'b0;
        tx_fire   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (req_ready) begin
                    state_nxt = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_valid) begin
                    if (hold_mode) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = ST_SEND;
                    end
                end
`ifdef BRIDGE_RSP_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    tmo_hit   = 1'b1;
                    state_nxt = hold_mode ? ST_IDLE : ST_SEND;
                end
`endif
            end
            ST_SEND: begin
                if (!u_tx_busy) begin
                    tx_fire   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            hold_mode  <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            u_tx_data  <= '0;
            u_tx_en    <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            state   <= state_nxt;
            u_tx_en <= tx_fire;
            if (fifo_pop) begin
                hold_mode  <= fifo_rd_data[MODE_BIT];
                hold_addr  <= fifo_rd_data[ADDR_LSB +: ADDR_WIDTH];
                hold_wdata <= fifo_rd_data[MODE_BIT] ? fifo_rd_data[WDATA_LSB +: DATA_WIDTH] : '0;
            end
            // A timed-out read returns all-ones so the far slave still completes.
            if (capture) begin
                u_tx_data <= rsp_rdata;
            end else if (tmo_hit && !hold_mode) begin
                u_tx_data <= '1;
            end
            if (frame_drop) begin
                ovf_err <= 1'b1;
            end
        end
    end

    assign req_valid = (state == ST_ISSUE);
    assign req_mode  = hold_mode;
    assign req_addr  = hold_addr;
    assign req_wdata = hold_wdata;

endmodule

// File: tb/tb_bus_bridge_req_sequencer.sv
// tb_bus_bridge_req_sequencer: directed vectors for bus_bridge_req_sequencer.
// With BRIDGE_RSP_TIMEOUT_EN defined the read-timeout scenario is also exercised.
module tb_bus_bridge_req_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        u_rx_ready;
    logic [20:0] u_rx_data;
    logic        u_tx_busy;
    logic        u_tx_en;
    logic [7:0]  u_tx_data;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        ovf_err;
    logic        tmo_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_bridge_req_sequencer #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (12),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .u_rx_ready (u_rx_ready),
        .u_rx_data  (u_rx_data),
        .u_tx_busy  (u_tx_busy),
        .u_tx_en    (u_tx_en),
        .u_tx_data  (u_tx_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ovf_err    (ovf_err),
        .tmo_err    (tmo_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] frm(input logic mode, input logic [7:0] wd, input logic [11:0] a);
        return {mode, wd, a};
    endfunction

    task automatic push_frame(input logic [20:0] f);
        @(posedge clk); #1;
        u_rx_ready = 1'b1;
        u_rx_data  = f;
    endtask

    task automatic idle_rx();
        @(posedge clk); #1;
        u_rx_ready = 1'b0;
    endtask

    // Waits (bounded) for req_valid at a falling edge, then checks the request fields.
    task automatic wait_req(input string tag, input logic mode, input logic [11:0] a, input logic [7:0] wd);
        int n = 0;
        @(negedge clk);
        while (!req_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, req_valid, 1'b1);
        check({tag, "_mode"}, req_mode, mode);
        check({tag, "_addr"}, req_addr, a);
        check({tag, "_wdata"}, req_wdata, wd);
    endtask

    task automatic rsp_pulse(input logic [7:0] rd);
        @(posedge clk); #1;
        rsp_valid = 1'b1;
        rsp_rdata = rd;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
    endtask

    // Cycle 0 of the window is the first WAIT_RSP cycle. Optionally pulses rsp_valid there,
    // holds u_tx_busy for cycles 0..busy_last, and reports u_tx_en pulses seen.
    task automatic rsp_and_watch(input logic do_rsp, input logic [7:0] rd, input int busy_last,
                                 output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            rsp_valid = do_rsp && (i == 0);
            rsp_rdata = rd;
            u_tx_busy = (i <= busy_last);
            @(negedge clk);
            if (u_tx_en) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        u_tx_busy = 1'b0;
    endtask

    int cnt, first, rv_cnt, tx_cnt;

    initial begin
        rstn       = 1'b0;
        u_rx_ready = 1'b0;
        u_rx_data  = '0;
        u_tx_busy  = 1'b0;
        req_ready  = 1'b1;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_u_tx_en", u_tx_en, 1'b0);
        check("rst_u_tx_data", u_tx_data, 8'h00);
        check("rst_req_addr", req_addr, 12'h000);
        check("rst_ovf_err", ovf_err, 1'b0);
        check("rst_tmo_err", tmo_err, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // 1: write frame, request appears two cycles after the RX strobe
        push_frame(frm(1'b1, 8'hA5, 12'h123));
        @(negedge clk);
        check("t1_rv_n0", req_valid, 1'b0);
        idle_rx();
        @(negedge clk);
        check("t1_rv_n1", req_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_rv_n2", req_valid, 1'b1);
        check("t1_mode", req_mode, 1'b1);
        check("t1_addr", req_addr, 12'h123);
        check("t1_wdata", req_wdata, 8'hA5);
        rsp_and_watch(1'b1, 8'h00, -1, cnt, first);
        check("t1_no_tx", cnt, 0);

        // 2: read frame, one TX pulse two cycles after the response
        push_frame(frm(1'b0, 8'h77, 12'h0FF));
        idle_rx();
        wait_req("t2", 1'b0, 12'h0FF, 8'h00);
        rsp_and_watch(1'b1, 8'h3C, -1, cnt, first);
        check("t2_tx_cnt", cnt, 1);
        check("t2_tx_cycle", first, 2);
        check("t2_tx_data", u_tx_data, 8'h3C);

        // 3: six back-to-back frames while the master port stalls
        req_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push_frame(frm(1'b1, 8'h50 + 8'(k), 12'h200 + 12'(k)));
        end
        idle_rx();
        @(negedge clk);
        check("t3_ovf", ovf_err, 1'b1);
        check("t3_hold_rv", req_valid, 1'b1);
        check("t3_hold_addr", req_addr, 12'h200);
        @(posedge clk); #1;
        req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_req($sformatf("t3_req%0d", k), 1'b1, 12'h200 + 12'(k), 8'h50 + 8'(k));
            rsp_pulse(8'h00);
        end
        rv_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (req_valid) rv_cnt++;
        end
        check("t3_no_6th", rv_cnt, 0);
        check("t3_ovf_sticky", ovf_err, 1'b1);

        // 4: TX busy for 20 cycles after the read completes
        push_frame(frm(1'b0, 8'h00, 12'h345));
        idle_rx();
        wait_req("t4", 1'b0, 12'h345, 8'h00);
        rsp_and_watch(1'b1, 8'h9E, 20, cnt, first);
        check("t4_tx_cnt", cnt, 1);
        check("t4_tx_cycle", first, 22);
        check("t4_tx_data", u_tx_data, 8'h9E);

        // 5: reset while waiting for a response with two frames queued
        push_frame(frm(1'b0, 8'h00, 12'h0AA));
        push_frame(frm(1'b1, 8'hBB, 12'h0BB));
        push_frame(frm(1'b1, 8'hCC, 12'h0CC));
        idle_rx();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_rv", req_valid, 1'b0);
        check("t5_tx_en", u_tx_en, 1'b0);
        check("t5_tx_data", u_tx_data, 8'h00);
        check("t5_addr", req_addr, 12'h000);
        check("t5_wdata", req_wdata, 8'h00);
        check("t5_ovf_clr", ovf_err, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        rv_cnt = 0;
        tx_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            rsp_valid = (i == 3);
            rsp_rdata = 8'h55;
            @(negedge clk);
            if (req_valid) rv_cnt++;
            if (u_tx_en) tx_cnt++;
        end
        rsp_valid = 1'b0;
        check("t5_no_req", rv_cnt, 0);
        check("t5_no_tx", tx_cnt, 0);

`ifdef BRIDGE_RSP_TIMEOUT_EN
        // 6: read with no response times out after 16 cycles
        push_frame(frm(1'b0, 8'h11, 12'h7E0));
        idle_rx();
        wait_req("t6", 1'b0, 12'h7E0, 8'h00);
        rsp_and_watch(1'b0, 8'h00, -1, cnt, first);
        check("t6_tx_cnt", cnt, 1);
        check("t6_tx_cycle", first, 17);
        check("t6_tmo", tmo_err, 1'b1);
        check("t6_tx_data", u_tx_data, 8'hFF);
        rsp_pulse(8'h12);
        @(negedge clk);
        check("t6_late_ignored", u_tx_data, 8'hFF);
        check("t6_late_no_tx", u_tx_en, 1'b0);
        push_frame(frm(1'b1, 8'h66, 12'h456));
        idle_rx();
        wait_req("t6_next", 1'b1, 12'h456, 8'h66);
        rsp_pulse(8'h00);
`else
        check("tmo_tied_0", tmo_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
